// File: rtl/ad9854_pkg.sv
//------------------------------------------------------------------------------
// Module  : ad9854_pkg
// Brief   : Shared types and constants for the AD9854 parallel-bus read path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package ad9854_pkg;

    localparam int C_ADDR_W    = 6;
    localparam int C_DATA_W    = 8;
    localparam int C_MAX_BURST = 6;
    localparam int C_RDATA_W   = C_DATA_W * C_MAX_BURST;

    localparam logic [C_ADDR_W-1:0] C_REG_PHASE1 = 6'h00;
    localparam logic [C_ADDR_W-1:0] C_REG_FTW1   = 6'h04;
    localparam logic [C_ADDR_W-1:0] C_REG_FTW2   = 6'h0A;
    localparam logic [C_ADDR_W-1:0] C_REG_CTRL   = 6'h1D;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // A zero count still reads one byte; 7 exceeds the 48-bit result and is clamped.
    function automatic logic [2:0] eff_count(input logic [2:0] n);
        logic [2:0] r;
        r = n;
        if (n == 3'd0) r = 3'd1;
        else if (n == 3'd7) r = 3'(C_MAX_BURST);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ad9854_reader.sv
//------------------------------------------------------------------------------
// Module  : ad9854_reader
// Brief   : Burst reader for the AD9854 DDS parallel port (1..6 bytes, MSB first).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ad9854_reader
    import ad9854_pkg::*;
#(
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [C_ADDR_W-1:0]  base_addr,
    input  logic [2:0]           byte_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [C_RDATA_W-1:0] rdata,
    output logic [C_ADDR_W-1:0]  dds_addr,
    output logic                 dds_rd_n,
    input  logic [C_DATA_W-1:0]  dds_data_i,
    output logic                 dds_bus_busy
);

    localparam logic [3:0] C_LOW_LAST  = 4'(RD_LOW_CYC - 1);
    localparam logic [3:0] C_HIGH_LAST = 4'(RD_HIGH_CYC - 1);

    state_t                 r_state;
    logic [3:0]             r_phase;
    logic [C_ADDR_W-1:0]    r_addr;
    logic [2:0]             r_left;
    logic [C_RDATA_W-1:0]   r_rdata;
    logic                   r_rd_n;
    logic                   r_busy;
    logic                   r_done;

    state_t                 w_state_nx;
    logic [3:0]             w_phase_nx;
    logic [C_ADDR_W-1:0]    w_addr_nx;
    logic [2:0]             w_left_nx;
    logic [C_RDATA_W-1:0]   w_rdata_nx;
    logic                   w_rd_n_nx;
    logic                   w_busy_nx;
    logic                   w_done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= 4'd0;
            r_addr  <= '0;
            r_left  <= 3'd0;
            r_rdata <= '0;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_addr  <= w_addr_nx;
            r_left  <= w_left_nx;
            r_rdata <= w_rdata_nx;
            r_rd_n  <= w_rd_n_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Outputs are next-state decoded so rd_n/busy/done all come straight from flops.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_addr_nx  = r_addr;
        w_left_nx  = r_left;
        w_rdata_nx = r_rdata;
        w_rd_n_nx  = 1'b1;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_SETUP;
                    w_addr_nx  = base_addr;
                    w_left_nx  = eff_count(byte_cnt);
                    w_rdata_nx = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nx = ST_STROBE;
                w_phase_nx = 4'd0;
                w_rd_n_nx  = 1'b0;
            end
            ST_STROBE: begin
                w_rd_n_nx = 1'b0;
                if (r_phase == C_LOW_LAST) begin
                    w_rdata_nx = {r_rdata[C_RDATA_W-C_DATA_W-1:0], dds_data_i};
                    w_left_nx  = r_left - 3'd1;
                    w_state_nx = ST_RECOVER;
                    w_phase_nx = 4'd0;
                    w_rd_n_nx  = 1'b1;
                end else begin
                    w_phase_nx = r_phase + 4'd1;
                end
            end
            ST_RECOVER: begin
                if (r_phase == C_HIGH_LAST) begin
                    w_phase_nx = 4'd0;
                    if (r_left != 3'd0) begin
                        // Address only moves while rd_n is high, so it is stable under the strobe.
                        w_state_nx = ST_SETUP;
                        w_addr_nx  = r_addr + 1'b1;
                    end else begin
                        w_state_nx = ST_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_phase_nx = r_phase + 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign dds_addr     = r_addr;
    assign dds_rd_n     = r_rd_n;
    assign dds_bus_busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ad9854_reader.sv
//------------------------------------------------------------------------------
// Module  : tb_ad9854_reader
// Brief   : Directed self-checking bench for ad9854_reader with a byte-array DDS model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ad9854_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = 6'h00;
    logic [2:0]  byte_cnt = 3'd0;
    logic        busy;
    logic        done;
    logic [47:0] rdata;
    logic [5:0]  dds_addr;
    logic        dds_rd_n;
    logic [7:0]  dds_data_i;
    logic        dds_bus_busy;

    logic [7:0]  mem [64];
    int          total = 0;
    int          bad = 0;

    logic [5:0]  addr_log [16];
    int          width_log [16];
    int          n_pulse = 0;
    int          n_done = 0;
    int          cur_w = 0;
    logic        prev_rd_n = 1'b1;
    logic        prev_done = 1'b0;
    logic [5:0]  prev_addr = 6'h00;

    always #5 clk = ~clk;

    assign dds_data_i = mem[dds_addr];

    ad9854_reader #(.RD_LOW_CYC(4), .RD_HIGH_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .byte_cnt     (byte_cnt),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .dds_addr     (dds_addr),
        .dds_rd_n     (dds_rd_n),
        .dds_data_i   (dds_data_i),
        .dds_bus_busy (dds_bus_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor plus the always-on protocol checks.
    always @(negedge clk) begin
        if (!prev_rd_n && !dds_rd_n) chk("addr_stable", {58'd0, dds_addr}, {58'd0, prev_addr});
        chk("bus_busy_eq_busy", {63'd0, dds_bus_busy}, {63'd0, busy});
        if (prev_done) chk("done_single", {63'd0, done}, 64'd0);
        if (!dds_rd_n) begin
            if (prev_rd_n) begin
                if (n_pulse < 16) addr_log[n_pulse] = dds_addr;
                cur_w = 0;
            end
            cur_w++;
        end else if (!prev_rd_n) begin
            if (n_pulse < 16) width_log[n_pulse] = cur_w;
            n_pulse++;
        end
        if (done) n_done++;
        prev_rd_n = dds_rd_n;
        prev_done = done;
        prev_addr = dds_addr;
    end

    // Pulses start, waits for done; cyc is the negedge index (1 = first cycle after acceptance).
    task automatic run_burst(input logic [5:0] a, input logic [2:0] n,
                             input int restart_at, output int cyc);
        n_pulse = 0;
        n_done  = 0;
        @(negedge clk);
        base_addr = a;
        byte_cnt  = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("rdata_cleared", {16'd0, rdata}, 64'd0);
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (c == restart_at) begin
                base_addr = 6'h20;
                byte_cnt  = 3'd1;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                cyc = c;
                break;
            end
        end
        start = 1'b0;
        chk("busy_in_done", {63'd0, busy}, 64'd0);
    endtask

    int cyc;
    logic [47:0] held;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i ^ 8'hC5);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_n", {63'd0, dds_rd_n}, 64'd1);
        chk("rst_addr", {58'd0, dds_addr}, 64'd0);
        chk("rst_rdata", {16'd0, rdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_bus_busy", {63'd0, dds_bus_busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Six bytes from FTW1
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33;
        mem[7] = 8'h44; mem[8] = 8'h55; mem[9] = 8'h66;
        run_burst(6'h04, 3'd6, 0, cyc);
        chk("a_done_cycle", 64'(cyc), 64'd43);
        chk("a_rdata", {16'd0, rdata}, 64'h112233445566);
        @(negedge clk);
        chk("a_pulses", 64'(n_pulse), 64'd6);
        for (int i = 0; i < 6; i++) chk("a_addr", {58'd0, addr_log[i]}, 64'(4 + i));
        chk("a_done_count", 64'(n_done), 64'd1);
        held = rdata;
        repeat (3) @(negedge clk);
        chk("a_rdata_held", {16'd0, rdata}, 64'h112233445566);

        // byte_cnt 0 reads a single byte
        mem[6'h1D] = 8'hAB;
        run_burst(6'h1D, 3'd0, 0, cyc);
        chk("b_done_cycle", 64'(cyc), 64'd8);
        chk("b_rdata", {16'd0, rdata}, 64'hAB);
        @(negedge clk);
        chk("b_pulses", 64'(n_pulse), 64'd1);
        chk("b_addr", {58'd0, addr_log[0]}, 64'h1D);

        // Address wrap 0x3F -> 0x00
        mem[6'h3E] = 8'hA1; mem[6'h3F] = 8'hB2; mem[0] = 8'hC3;
        run_burst(6'h3E, 3'd3, 0, cyc);
        chk("c_done_cycle", 64'(cyc), 64'd22);
        chk("c_rdata", {16'd0, rdata}, 64'hA1B2C3);
        @(negedge clk);
        chk("c_pulses", 64'(n_pulse), 64'd3);
        chk("c_addr0", {58'd0, addr_log[0]}, 64'h3E);
        chk("c_addr1", {58'd0, addr_log[1]}, 64'h3F);
        chk("c_addr2", {58'd0, addr_log[2]}, 64'h00);
        for (int i = 0; i < 3; i++) chk("c_width", 64'(width_log[i]), 64'd4);

        // byte_cnt 7 clamps to 6; a start mid-burst is ignored
        for (int i = 0; i < 6; i++) mem[6'h10 + i] = 8'(i + 1);
        run_burst(6'h10, 3'd7, 10, cyc);
        chk("d_done_cycle", 64'(cyc), 64'd43);
        chk("d_rdata", {16'd0, rdata}, 64'h010203040506);
        repeat (4) @(negedge clk);
        chk("d_pulses", 64'(n_pulse), 64'd6);
        chk("d_done_count", 64'(n_done), 64'd1);
        chk("d_idle_busy", {63'd0, busy}, 64'd0);

        // Reset during the third strobe aborts the burst
        n_pulse = 0;
        n_done  = 0;
        @(negedge clk);
        base_addr = 6'h04;
        byte_cnt  = 3'd6;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !(n_pulse == 2 && !dds_rd_n); c++) @(negedge clk);
        chk("e_in_third_strobe", {63'd0, dds_rd_n}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rd_n_async", {63'd0, dds_rd_n}, 64'd1);
        chk("e_busy_async", {63'd0, busy}, 64'd0);
        chk("e_rdata_async", {16'd0, rdata}, 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("e_no_done", 64'(n_done), 64'd0);

        mem[6'h0A] = 8'h5A; mem[6'h0B] = 8'hA5;
        run_burst(6'h0A, 3'd2, 0, cyc);
        chk("e_done_cycle", 64'(cyc), 64'd15);
        chk("e_rdata", {16'd0, rdata}, 64'h5AA5);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ad9854_reader.md
AD9854_READER -- requirements
Module: ad9854_reader

Interface
REQ-001 SHALL have parameter RD_LOW_CYC, default 4: number of clk cycles dds_rd_n is held low per byte (legal 1..15).
REQ-002 SHALL have parameter RD_HIGH_CYC, default 2: number of clk cycles dds_rd_n is held high after each byte (legal 1..15).
REQ-003 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr  input  6: DDS register address of the first byte.
REQ-007 SHALL have port byte_cnt  input  3: number of bytes to read.
REQ-008 SHALL have port busy  output  1: high while a burst is in progress.
REQ-009 SHALL have port done  output  1: one-cycle pulse when rdata is valid.
REQ-010 SHALL have port rdata  output  48: assembled read data.
REQ-011 SHALL have port dds_addr  output  6: DDS parallel address bus.
REQ-012 SHALL have port dds_rd_n  output  1: DDS read strobe, active low.
REQ-013 SHALL have port dds_data_i  input  8: DDS parallel data bus, read direction.
REQ-014 SHALL have port dds_bus_busy  output  1: equal to busy; tells the write path not to drive the data bus or pulse WR.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> STROBE -> RECOVER -> (SETUP | DONE) -> IDLE.
REQ-016 SHALL leave IDLE only when start=1; start SHALL be ignored in any state other than IDLE.
REQ-017 SHALL latch base_addr and byte_cnt when start is accepted; byte_cnt 0 SHALL be treated as 1, and values of 7 SHALL be clamped to 6.
REQ-018 SHALL clear rdata to 0 when start is accepted.
REQ-019 SHALL hold SETUP for 1 cycle with dds_rd_n=1 and dds_addr stable at the current address.
REQ-020 SHALL hold STROBE for RD_LOW_CYC cycles with dds_rd_n=0.
REQ-021 SHALL sample dds_data_i at the clock edge that ends the last STROBE cycle, and SHALL form rdata as {rdata[39:0], dds_data_i}.
REQ-022 Result SHALL therefore be right-justified, with the first byte read as the most significant valid byte.
REQ-023 SHALL hold RECOVER for RD_HIGH_CYC cycles with dds_rd_n=1.
REQ-024 After RECOVER, SHALL increment the address (6-bit, 0x3F wraps to 0x00) and return to SETUP if bytes remain; otherwise SHALL go to DONE.
REQ-025 SHALL assert done for exactly 1 cycle in DONE, with rdata final, then return to IDLE; busy SHALL be 0 in DONE.
REQ-026 SHALL assert busy from the cycle after start acceptance until DONE is entered.
REQ-027 Latency from the start-sampling edge to the done pulse SHALL be N*(1+RD_LOW_CYC+RD_HIGH_CYC)+1 cycles, N being the effective byte count.
REQ-028 rdata SHALL hold its value from DONE until the next accepted start.
REQ-029 dds_rd_n SHALL be driven from a register (glitch-free), and dds_addr SHALL NOT change while dds_rd_n=0.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force state=IDLE, dds_rd_n=1, dds_addr=0, rdata=0, busy=0, done=0, and dds_bus_busy=0.
REQ-031 Reset asserted mid-burst SHALL abort it with no done pulse; the first start after reset release SHALL begin a fresh burst.

Structure
REQ-032 Shared package ad9854_pkg SHALL hold the FSM state enum, address width (6), data width (8), max burst (6), and register base constants: PHASE1=0x00, FTW1=0x04, FTW2=0x0A, CTRL=0x1D.
REQ-033 SHALL be a single module containing one 4-bit phase counter shared by STROBE and RECOVER; no sub-module is required.

Verification
REQ-034 base_addr=0x04, byte_cnt=6, model returns 0x11..0x66 -> addresses 0x04..0x09 in order; rdata=0x112233445566; done at cycle 43 (defaults).
REQ-035 base_addr=0x1D, byte_cnt=0 -> one byte read from 0x1D; rdata=0x0000000000AB for model byte 0xAB; done at cycle 8.
REQ-036 base_addr=0x3E, byte_cnt=3 -> addresses 0x3E, 0x3F, 0x00; 3 dds_rd_n low pulses, each 4 cycles wide.
REQ-037 start pulsed again while busy -> ignored; exactly one done pulse; byte count unchanged.
REQ-038 rst_n low during the 3rd STROBE -> dds_rd_n=1 immediately, no done; a new burst after release completes correctly.
REQ-039 Assertion checks (all tests): dds_addr stable while dds_rd_n=0; dds_bus_busy==busy; done is a single-cycle pulse.
